// File: rtl/sprite_mover.sv
// sprite_mover: one rectangular sprite at a fixed column that moves up/down
// once per frame tick. Each frame erases the old image, updates the row,
// then redraws, streaming one pixel per clock to the VGA adapter.
module sprite_mover #(
  parameter int                  X_W           = 8,
  parameter int                  Y_W           = 7,
  parameter int                  COLOUR_W      = 3,
  parameter int                  SCREEN_H      = 120,
  parameter int                  SPRITE_W      = 4,
  parameter int                  SPRITE_H      = 4,
  parameter int                  X_POS         = 10,
  parameter int                  Y_INIT        = 56,
  parameter int                  STEP          = 1,
  parameter int                  FRAME_DIV     = 833333,
  parameter logic [COLOUR_W-1:0] SPRITE_COLOUR = 3'b111,
  parameter logic [COLOUR_W-1:0] BG_COLOUR     = 3'b000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                up,
  input  logic                down,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                frame_done,
  output logic [Y_W-1:0]      sprite_y
);

  localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int YE_W  = Y_W + 1;
  localparam logic [YE_W-1:0]  Y_MAX_E   = YE_W'(SCREEN_H - SPRITE_H);
  localparam logic [YE_W-1:0]  STEP_E    = YE_W'(STEP);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_DIV - 1);
  localparam logic [3:0]       PX_LAST   = 4'(SPRITE_W - 1);
  localparam logic [3:0]       PY_LAST   = 4'(SPRITE_H - 1);

  typedef enum logic [1:0] {S_WAIT, S_ERASE, S_UPDATE, S_DRAW} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                pending_q;
  logic [3:0]          px_q, py_q;
  logic [3:0]          px_d, py_d;
  logic [Y_W-1:0]      sprite_y_q;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                plot_q, busy_q, frame_done_q;

  logic                tick;
  logic                last_px, last_py, last_pix;
  logic [X_W-1:0]      pix_x;
  logic [Y_W-1:0]      pix_y;

  // Move toward row 0, clamping at the top edge; widened so it never wraps.
  function automatic logic [Y_W-1:0] sat_up(input logic [Y_W-1:0] cur);
    logic [YE_W-1:0] ext;
    ext = {1'b0, cur};
    if (ext >= STEP_E) return Y_W'(ext - STEP_E);
    return '0;
  endfunction

  // Move toward larger rows, clamping so the sprite stays fully on screen.
  function automatic logic [Y_W-1:0] sat_down(input logic [Y_W-1:0] cur);
    logic [YE_W-1:0] sum;
    sum = {1'b0, cur} + STEP_E;
    if (sum <= Y_MAX_E) return Y_W'(sum);
    return Y_W'(Y_MAX_E);
  endfunction

  assign tick     = enable && (cnt_q == CNT_LAST);
  assign last_px  = (px_q == PX_LAST);
  assign last_py  = (py_q == PY_LAST);
  assign last_pix = last_px && last_py;
  assign pix_x    = X_W'(X_POS) + X_W'(px_q);
  assign pix_y    = sprite_y_q + Y_W'(py_q);

  // Next position in the raster walk: px fastest, py wraps after the last row.
  always_comb begin
    px_d = px_q + 4'd1;
    py_d = py_q;
    if (last_px) begin
      px_d = '0;
      py_d = last_py ? 4'd0 : py_q + 4'd1;
    end
  end

  // Frame-tick divider; frozen while paused so a frame period is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Erase/update/draw sequencer with registered pixel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_DRAW;
      px_q         <= '0;
      py_q         <= '0;
      pending_q    <= 1'b0;
      sprite_y_q   <= Y_W'(Y_INIT);
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      if (tick && (state_q != S_WAIT)) pending_q <= 1'b1;
      case (state_q)
        S_WAIT: begin
          // plot_q is still high only in the first WAIT cycle after the last DRAW pixel
          frame_done_q <= plot_q;
          if ((tick || pending_q) && enable) begin
            state_q   <= S_ERASE;
            pending_q <= 1'b0;
          end
        end
        S_ERASE: begin
          x_q      <= pix_x;
          y_q      <= pix_y;
          colour_q <= BG_COLOUR;
          plot_q   <= 1'b1;
          busy_q   <= 1'b1;
          px_q     <= px_d;
          py_q     <= py_d;
          if (last_pix) state_q <= S_UPDATE;
        end
        S_UPDATE: begin
          busy_q <= 1'b1;
          if (up && !down)      sprite_y_q <= sat_up(sprite_y_q);
          else if (down && !up) sprite_y_q <= sat_down(sprite_y_q);
          state_q <= S_DRAW;
        end
        S_DRAW: begin
          x_q      <= pix_x;
          y_q      <= pix_y;
          colour_q <= SPRITE_COLOUR;
          plot_q   <= 1'b1;
          busy_q   <= 1'b1;
          px_q     <= px_d;
          py_q     <= py_d;
          if (last_pix) state_q <= S_WAIT;
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign colour     = colour_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign sprite_y   = sprite_y_q;

endmodule
